// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / data-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [1:0] MASK_BYTE = 2'd0;
  localparam logic [1:0] MASK_HALF = 2'd1;
  localparam logic [1:0] MASK_WORD = 2'd2;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the fetch, data and memory-backend buses seen by the arbiter.
// Every request channel: a transfer happens on a clock edge where valid and ready
// are both high; the requester holds its fields stable while valid is high and ready low.
interface mem_access_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;

  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_write;
  logic [1:0]  dm_maskmode;
  logic        dm_sext;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_data;
  logic        dm_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_write;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  if_req_valid, if_addr,
    input  dm_req_valid, dm_addr, dm_wdata, dm_write, dm_maskmode, dm_sext,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output if_req_ready, if_resp_valid, if_resp_data,
    output dm_req_ready, dm_resp_valid, dm_resp_data, dm_resp_err,
    output mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_write
  );

  modport master (
    output if_req_valid, if_addr,
    output dm_req_valid, dm_addr, dm_wdata, dm_write, dm_maskmode, dm_sext,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  dm_req_ready, dm_resp_valid, dm_resp_data, dm_resp_err,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wstrb, mem_write
  );
endinterface

// File: rtl/mem_access_arbiter_lane_align.sv
// Combinational byte-lane logic: store strobe/data steering, alignment check,
// and load extract with sign/zero extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_mask,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_wstrb,
  output logic [31:0] o_st_wdata,
  output logic        o_misalign,
  input  logic [1:0]  i_ld_off,
  input  logic [1:0]  i_ld_mask,
  input  logic        i_ld_sext,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_st_wstrb = 4'h0;
    o_st_wdata = 32'h0;
    o_misalign = 1'b0;
    case (i_st_mask)
      MASK_BYTE: begin
        o_st_wstrb = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      MASK_HALF: begin
        o_st_wstrb = 4'b0011 << i_st_off;
        o_st_wdata = {2{i_st_wdata[15:0]}};
        o_misalign = i_st_off[0];
      end
      MASK_WORD: begin
        o_st_wstrb = 4'hF;
        o_st_wdata = i_st_wdata;
        o_misalign = |i_st_off;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_shifted = i_ld_word >> {i_ld_off, 3'b000};
    o_ld_data = w_shifted;
    case (i_ld_mask)
      MASK_BYTE: o_ld_data = {{24{i_ld_sext & w_shifted[7]}}, w_shifted[7:0]};
      MASK_HALF: o_ld_data = {{16{i_ld_sext & w_shifted[15]}}, w_shifted[15:0]};
      default:   o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbiter sharing one memory backend between fetch and data ports, one transaction at a time.
// Optional WAIT timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_arbiter_if.slave   bus,
  output state_t                o_dbg_state
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  state_t      r_state, w_next;
  owner_t      r_owner;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_write, r_sext, r_err;
  logic [1:0]  r_off, r_mask;
  logic [SW-1:0] r_streak;

  logic        w_grant_dm, w_grant_if, w_hs_dm, w_hs_if, w_misalign, w_timeout, w_dm_resp;
  logic [3:0]  w_st_wstrb;
  logic [31:0] w_st_wdata, w_ld_data;

  mem_lane_align u_align (
    .i_st_off   (bus.dm_addr[1:0]),
    .i_st_mask  (bus.dm_maskmode),
    .i_st_wdata (bus.dm_wdata),
    .o_st_wstrb (w_st_wstrb),
    .o_st_wdata (w_st_wdata),
    .o_misalign (w_misalign),
    .i_ld_off   (r_off),
    .i_ld_mask  (r_mask),
    .i_ld_sext  (r_sext),
    .i_ld_word  (bus.mem_resp_data),
    .o_ld_data  (w_ld_data)
  );

  // Data wins contention until it has taken MAX_DATA_STREAK grants in a row over a waiting fetch.
  assign w_grant_dm = bus.dm_req_valid & (~bus.if_req_valid | (r_streak != SW'(MAX_DATA_STREAK)));
  assign w_grant_if = bus.if_req_valid & ~w_grant_dm;
  assign bus.if_req_ready = (r_state == IDLE) & w_grant_if & ~reset;
  assign bus.dm_req_ready = (r_state == IDLE) & w_grant_dm & ~reset;
  assign w_hs_if = bus.if_req_valid & bus.if_req_ready;
  assign w_hs_dm = bus.dm_req_valid & bus.dm_req_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [31:0] r_wait_cnt;
  assign w_timeout = (r_state == WAIT) & ~bus.mem_resp_valid &
                     (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_wait_cnt <= 32'd0;
    else if (r_state != WAIT) r_wait_cnt <= 32'd0;
    else                      r_wait_cnt <= r_wait_cnt + 32'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs_dm)      w_next = w_misalign ? ERR : ISSUE;
        else if (w_hs_if) w_next = ISSUE;
      end
      ISSUE:   if (bus.mem_req_ready) w_next = WAIT;
      WAIT:    if (bus.mem_resp_valid | w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner  <= OWN_IF;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_wstrb  <= 4'h0;
      r_write  <= 1'b0;
      r_off    <= 2'd0;
      r_mask   <= 2'd0;
      r_sext   <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_streak <= '0;
    end else begin
      if (w_hs_if) begin
        r_owner  <= OWN_IF;
        r_addr   <= bus.if_addr & 32'hFFFF_FFFC;
        r_wdata  <= 32'h0;
        r_wstrb  <= 4'h0;
        r_write  <= 1'b0;
        r_off    <= 2'd0;
        r_mask   <= MASK_WORD;
        r_sext   <= 1'b0;
        r_err    <= 1'b0;
        r_streak <= '0;
      end
      if (w_hs_dm) begin
        r_owner <= OWN_DM;
        r_addr  <= word_addr(bus.dm_addr);
        r_wdata <= bus.dm_write ? w_st_wdata : 32'h0;
        r_wstrb <= bus.dm_write ? w_st_wstrb : 4'h0;
        r_write <= bus.dm_write;
        r_off   <= bus.dm_addr[1:0];
        r_mask  <= bus.dm_maskmode;
        r_sext  <= bus.dm_sext;
        r_err   <= 1'b0;
        if (bus.if_req_valid && (r_streak != SW'(MAX_DATA_STREAK)))
          r_streak <= r_streak + SW'(1);
      end
      if (r_state == WAIT) begin
        if (bus.mem_resp_valid) begin
          r_rdata <= r_write ? 32'h0 : w_ld_data;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= 32'h0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign w_dm_resp         = (r_state == RESP) & (r_owner == OWN_DM);
  assign bus.mem_req_valid = (r_state == ISSUE);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wstrb     = r_wstrb;
  assign bus.mem_write     = r_write;
  assign bus.if_resp_valid = (r_state == RESP) & (r_owner == OWN_IF);
  assign bus.if_resp_data  = bus.if_resp_valid ? r_rdata : 32'h0;
  assign bus.dm_resp_valid = w_dm_resp | (r_state == ERR);
  assign bus.dm_resp_err   = (r_state == ERR) | (w_dm_resp & r_err);
  assign bus.dm_resp_data  = w_dm_resp ? r_rdata : 32'h0;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_err;
  int     n_chk;

  logic        cap_valid, cap_write, cap_early, cap_after;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_if_v, cap_dm_v, cap_dm_e;
  logic [31:0] cap_if_d, cap_dm_d;

  mem_access_arbiter_if bus ();

`ifdef MEM_ARB_TIMEOUT_EN
  mem_access_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
`else
  mem_access_arbiter #(.MAX_DATA_STREAK(4)) dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_addr        = 32'h0;
    bus.dm_req_valid   = 1'b0;
    bus.dm_addr        = 32'h0;
    bus.dm_wdata       = 32'h0;
    bus.dm_write       = 1'b0;
    bus.dm_maskmode    = 2'd0;
    bus.dm_sext        = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
  endtask

  task automatic drive_if(input logic [31:0] addr);
    bus.if_req_valid = 1'b1;
    bus.if_addr      = addr;
  endtask

  task automatic drive_dm(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                          input logic [1:0] mask, input logic sext);
    bus.dm_req_valid = 1'b1;
    bus.dm_addr      = addr;
    bus.dm_wdata     = wdata;
    bus.dm_write     = wr;
    bus.dm_maskmode  = mask;
    bus.dm_sext      = sext;
  endtask

  // Called in the IDLE cycle where the request is presented; returns one cycle after the response.
  task automatic backend(input logic [31:0] rdata, input bit hold);
    step();
    if (!hold) begin
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
    end
    bus.mem_req_ready = 1'b1;
    settle();
    cap_valid = bus.mem_req_valid;
    cap_addr  = bus.mem_addr;
    cap_wdata = bus.mem_wdata;
    cap_wstrb = bus.mem_wstrb;
    cap_write = bus.mem_write;
    step();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rdata;
    settle();
    cap_early = bus.if_resp_valid | bus.dm_resp_valid;
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
    cap_if_v = bus.if_resp_valid;
    cap_if_d = bus.if_resp_data;
    cap_dm_v = bus.dm_resp_valid;
    cap_dm_d = bus.dm_resp_data;
    cap_dm_e = bus.dm_resp_err;
    step();
    settle();
    cap_after = bus.if_resp_valid | bus.dm_resp_valid;
  endtask

  initial begin
    bit exp_d [10];
    int n;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    n_err = 0;
    n_chk = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    bus.if_req_valid = 1'b1;
    settle();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_resp", 32'({bus.if_resp_valid, bus.dm_resp_valid, bus.dm_resp_err}), 32'd0);
    bus.if_req_valid = 1'b0;
    step();
    reset = 1'b0;
    settle();

    // Fetch only, 3-cycle latency
    drive_if(32'h100);
    settle();
    chk("f1_if_ready", 32'(bus.if_req_ready), 32'd1);
    chk("f1_dm_ready", 32'(bus.dm_req_ready), 32'd0);
    backend(32'h0050_0093, 1'b0);
    chk("f1_mem_valid", 32'(cap_valid), 32'd1);
    chk("f1_mem_addr", cap_addr, 32'h100);
    chk("f1_mem_wr", 32'({cap_write, cap_wstrb}), 32'd0);
    chk("f1_early", 32'(cap_early), 32'd0);
    chk("f1_resp_v", 32'(cap_if_v), 32'd1);
    chk("f1_resp_d", cap_if_d, 32'h0050_0093);
    chk("f1_after", 32'(cap_after), 32'd0);

    // Byte loads with and without sign extension
    drive_dm(32'h203, 32'h0, 1'b0, MASK_BYTE, 1'b1);
    settle();
    chk("lb_dm_ready", 32'(bus.dm_req_ready), 32'd1);
    backend(32'h80FF_1234, 1'b0);
    chk("lb_mem_addr", cap_addr, 32'h200);
    chk("lb_wstrb", 32'(cap_wstrb), 32'd0);
    chk("lb_resp_v", 32'({cap_dm_v, cap_dm_e}), 32'b10);
    chk("lb_sext", cap_dm_d, 32'hFFFF_FF80);
    drive_dm(32'h203, 32'h0, 1'b0, MASK_BYTE, 1'b0);
    settle();
    backend(32'h80FF_1234, 1'b0);
    chk("lbu_zext", cap_dm_d, 32'h0000_0080);

    // Half store
    drive_dm(32'h302, 32'h0000_ABCD, 1'b1, MASK_HALF, 1'b0);
    settle();
    backend(32'hDEAD_BEEF, 1'b0);
    chk("sh_addr", cap_addr, 32'h300);
    chk("sh_wstrb", 32'(cap_wstrb), 32'h0000_000C);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_write", 32'(cap_write), 32'd1);
    chk("sh_resp", 32'({cap_dm_v, cap_dm_e}), 32'b10);
    chk("sh_resp_d", cap_dm_d, 32'h0);

    // Byte store, half load, word load
    drive_dm(32'h101, 32'h1234_565A, 1'b1, MASK_BYTE, 1'b0);
    settle();
    backend(32'h0, 1'b0);
    chk("sb_wstrb", 32'(cap_wstrb), 32'h0000_0002);
    chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    drive_dm(32'h202, 32'h0, 1'b0, MASK_HALF, 1'b1);
    settle();
    backend(32'h80FF_1234, 1'b0);
    chk("lh_sext", cap_dm_d, 32'hFFFF_80FF);
    drive_dm(32'h204, 32'h0, 1'b0, MASK_WORD, 1'b1);
    settle();
    backend(32'h80FF_1234, 1'b0);
    chk("lw_data", cap_dm_d, 32'h80FF_1234);

    // Fetch low address bits ignored
    drive_if(32'h107);
    settle();
    backend(32'hC0FF_EE00, 1'b0);
    chk("f2_mem_addr", cap_addr, 32'h104);
    chk("f2_resp_d", cap_if_d, 32'hC0FF_EE00);

    // Misaligned word: ERR pulse, no backend access
    drive_dm(32'h401, 32'h0, 1'b0, MASK_WORD, 1'b0);
    settle();
    chk("mw_dm_ready", 32'(bus.dm_req_ready), 32'd1);
    step();
    bus.dm_req_valid = 1'b0;
    settle();
    chk("mw_state", 32'(dbg_state), 32'(ERR));
    chk("mw_resp", 32'({bus.dm_resp_valid, bus.dm_resp_err, bus.mem_req_valid}), 32'b110);
    chk("mw_resp_d", bus.dm_resp_data, 32'h0);
    step();
    settle();
    chk("mw_after", 32'({bus.dm_resp_valid, bus.dm_resp_err, bus.mem_req_valid}), 32'b000);

    // Reserved maskmode and misaligned half
    drive_dm(32'h400, 32'h0, 1'b0, 2'd3, 1'b0);
    settle();
    step();
    bus.dm_req_valid = 1'b0;
    settle();
    chk("rsv_err", 32'({bus.dm_resp_valid, bus.dm_resp_err, bus.mem_req_valid}), 32'b110);
    step();
    drive_dm(32'h203, 32'h0, 1'b0, MASK_HALF, 1'b0);
    settle();
    step();
    bus.dm_req_valid = 1'b0;
    settle();
    chk("mh_err", 32'({bus.dm_resp_valid, bus.dm_resp_err, bus.mem_req_valid}), 32'b110);
    step();
    settle();

    // Response during the ISSUE handshake cycle is ignored
    drive_if(32'h180);
    settle();
    step();
    bus.if_req_valid   = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1111_1111;
    step();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("ign_state", 32'(dbg_state), 32'(WAIT));
    step();
    chk("ign_still_wait", 32'({dbg_state, bus.if_resp_valid}), 32'({WAIT, 1'b0}));
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h2222_2222;
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("ign_resp", bus.if_resp_data, 32'h2222_2222);
    step();
    settle();

    // Contention: both requesters held valid
    drive_if(32'h40);
    drive_dm(32'h500, 32'h0, 1'b0, MASK_WORD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("cont_dm_%0d", i), 32'(bus.dm_req_ready), 32'(exp_d[i]));
      chk($sformatf("cont_if_%0d", i), 32'(bus.if_req_ready), 32'(!exp_d[i]));
      backend(32'h0000_00A5, 1'b1);
    end
    bus.if_req_valid = 1'b0;
    bus.dm_req_valid = 1'b0;

    // Async reset in WAIT drops the transaction
    step();
    drive_if(32'h1C0);
    settle();
    step();
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    settle();
    chk("ar_wait", 32'(dbg_state), 32'(WAIT));
    reset = 1'b1;
    settle();
    chk("ar_state", 32'(dbg_state), 32'(IDLE));
    chk("ar_outs", 32'({bus.mem_req_valid, bus.if_resp_valid, bus.dm_resp_valid}), 32'd0);
    chk("ar_addr", bus.mem_addr, 32'h0);
    step();
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h3333_3333;
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("ar_no_resp", 32'({bus.if_resp_valid, bus.dm_resp_valid}), 32'd0);
    step();
    settle();
    chk("ar_no_resp2", 32'({dbg_state, bus.if_resp_valid, bus.dm_resp_valid}), 32'({IDLE, 2'b00}));

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout after 8 WAIT cycles with no backend response
    drive_dm(32'h600, 32'h0, 1'b0, MASK_WORD, 1'b0);
    settle();
    step();
    bus.dm_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    settle();
    n = 0;
    while (!bus.dm_resp_valid && n < 20) begin
      step();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd8);
    chk("to_err", 32'({bus.dm_resp_valid, bus.dm_resp_err}), 32'b11);
    chk("to_data", bus.dm_resp_data, 32'h0);
    step();
    bus.mem_resp_valid = 1'b1;
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk("to_late", 32'({dbg_state, bus.dm_resp_valid}), 32'({IDLE, 1'b0}));
`else
    n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares one single-ported memory backend between the CPU instruction-fetch port and the data port, with a valid/ready request handshake on every side.
- Sequences one outstanding transaction at a time. Performs data-side byte/half/word lane steering on writes, and mask/sign-extension on reads.
- Sits between the core's imem/dmem interfaces and the shared memory model.

Parameters:
- MAX_DATA_STREAK, 4: consecutive contested data grants allowed before ifetch is forced through.
- TIMEOUT_CYCLES, 64: cycles allowed in WAIT before a timeout; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address, word aligned
- if_resp_valid  out  1  one-cycle pulse: fetch data valid
- if_resp_data  out  32  fetched instruction
- dm_req_valid  in  1  data request valid
- dm_req_ready  out  1  data request accepted
- dm_addr  in  32  data byte address
- dm_wdata  in  32  write data, right-justified
- dm_write  in  1  1 = store, 0 = load
- dm_maskmode  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- dm_sext  in  1  sign-extend load result
- dm_resp_valid  out  1  one-cycle pulse: data response
- dm_resp_data  out  32  load result (0 for stores and errors)
- dm_resp_err  out  1  qualifies dm_resp_valid
- mem_req_valid  out  1  backend request valid
- mem_req_ready  in  1  backend accepts request
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-steered write data
- mem_wstrb  out  4  byte write strobes
- mem_write  out  1  backend store
- mem_resp_valid  in  1  backend response
- mem_resp_data  in  32  backend read word

Behaviour:
- Reset: all outputs 0; FSM = IDLE; streak counter = 0; latched request fields = 0.
- FSM states:
  - IDLE: grant computed combinationally. Ready is asserted only to the granted requester, and only in IDLE. Handshake (valid & ready) latches the request; next state is ISSUE, or ERR for a bad data request.
  - ISSUE: mem_req_valid = 1 with fields held stable until mem_req_ready, then go to WAIT.
  - WAIT: on mem_resp_valid, register the formatted result and go to RESP.
  - RESP: the owner's resp_valid = 1 for exactly one cycle, then go to IDLE.
  - ERR: dm_resp_valid = 1, dm_resp_err = 1, dm_resp_data = 0 for one cycle; no backend access; then go to IDLE.
- Minimum latency: handshake in cycle 0 → response pulse in cycle 3 (with mem_req_ready = 1 in cycle 1 and mem_resp_valid in cycle 2).
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - Streak increments (saturating) on a data grant while if_req_valid = 1; clears on a fetch grant.
- Data errors: maskmode = 3, half with addr[0] = 1, or word with addr[1:0] != 0 → ERR path.
- Store lane steering: off = addr[1:0].
  - Byte: wstrb = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011 << off; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'hF; wdata passes through.
- Loads: mem_wstrb = 0. Result = mem_resp_data >> (8*off), masked to 8/16/32 bits, then sign-extended from bit 7/15 if dm_sext, else zero-extended.
- Fetch: always a word read; if_addr[1:0] is ignored (forced 0).
- Store response: dm_resp_valid with data 0 once the backend ack (mem_resp_valid) arrives.
- mem_resp_valid outside WAIT is ignored, including the cycle of the ISSUE handshake.
- Async reset mid-transaction: FSM returns to IDLE immediately; the in-flight response is dropped; no resp_valid is emitted.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter counts up; after TIMEOUT_CYCLES cycles in WAIT without mem_resp_valid, the owner gets a resp pulse with data 0 and the FSM returns to IDLE.
  - For a data owner, dm_resp_err = 1.
  - For a fetch owner, if_resp_data = 0.
  - A late backend response is ignored.
- Undefined: no counter; WAIT holds indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP, ERR);
  - maskmode constants MASK_BYTE = 0, MASK_HALF = 1, MASK_WORD = 2;
  - the owner enum (OWN_IF, OWN_DM).
- Sub-module mem_lane_align: purely combinational; covers store strobe/data steering, load extract/extend, and misalignment detection.

Test Plan:
- Fetch only: if_addr = 0x100, backend returns 0x00500093 → if_resp_valid pulse with data 0x00500093, exactly 3 cycles after the handshake.
- Byte load: dm_addr = 0x203, sext = 1, backend word 0x80FF_1234 → dm_resp_data = 0xFFFFFF80. Same request with sext = 0 → 0x00000080.
- Half store: dm_addr = 0x302, wdata = 0xABCD → mem_addr = 0x300, mem_wstrb = 4'b1100, mem_wdata = 0xABCDABCD, mem_write = 1.
- Misaligned word: dm_addr = 0x401, maskmode = 2 → no mem_req_valid; dm_resp_err = 1 pulse one cycle after the handshake.
- Contention: both ports valid continuously, MAX_DATA_STREAK = 4 → grant order is D, D, D, D, I, D, D, D, D, I.
- Reset asserted during WAIT → outputs 0 the same cycle; a later mem_resp_valid produces no response. With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and no backend response → dm_resp_err pulse after 8 WAIT cycles.
